// File: rtl/vector_op_loader.sv
// vector_op_loader: Avalon-MM bridge that streams operand words from system memory
// into the vector_op accelerator, runs it, and writes its result back to memory.
module vector_op_loader #(
  parameter int ADDRESS_WIDTH = 2,
  parameter int OPERANDS      = 4,
  parameter int TIMEOUT       = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] slave_address,
  input  logic                     slave_read,
  output logic [31:0]              slave_readdata,
  input  logic                     slave_write,
  input  logic [31:0]              slave_writedata,
  output logic                     slave_waitrequest,
  output logic [31:0]              mem_address,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [31:0]              mem_writedata,
  input  logic [31:0]              mem_readdata,
  input  logic                     mem_waitrequest,
  output logic [2:0]               acc_address,
  output logic                     acc_read,
  output logic                     acc_write,
  output logic [31:0]              acc_writedata,
  input  logic [31:0]              acc_readdata,
  input  logic                     acc_waitrequest,
  input  logic                     acc_irq,
  output logic                     done_irq
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_COLLECT = 3'd5;
  localparam logic [2:0] S_STORE   = 3'd6;
  localparam logic [2:0] S_CLEAR   = 3'd7;

  localparam int              TW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0]      LAST_IDX  = 3'(OPERANDS - 1);
  localparam logic [TW-1:0]   TIMEOUT_V = TW'(TIMEOUT);

  logic [2:0]    state_r, state_nxt_s;
  logic [2:0]    idx_r, idx_nxt_s;
  logic [TW-1:0] timer_r, timer_nxt_s;
  logic [31:0]   data_r, data_nxt_s;
  logic [31:0]   result_r, result_nxt_s;
  logic [31:0]   src_r, dst_r;
  logic          done_r, busy_r, err_r;
  logic          set_busy_s, clr_busy_s, set_done_s, set_err_s;
  logic          csr_ctrl_wr_s, start_s, clr_flags_s;
  logic          mem_read_nxt_s, mem_write_nxt_s, acc_read_nxt_s, acc_write_nxt_s;
  logic [31:0]   mem_address_nxt_s, mem_writedata_nxt_s, acc_writedata_nxt_s;
  logic [2:0]    acc_address_nxt_s;

  assign slave_waitrequest = 1'b0;
  assign done_irq          = done_r;

  assign csr_ctrl_wr_s = slave_write && (slave_address == ADDRESS_WIDTH'(0));
  assign start_s       = csr_ctrl_wr_s && slave_writedata[0] && !busy_r;
  assign clr_flags_s   = csr_ctrl_wr_s && slave_writedata[1];

  // CSR read mux; idle bus reads as all ones
  always_comb begin
    slave_readdata = 32'hFFFF_FFFF;
    if (slave_read) begin
      case (slave_address)
        ADDRESS_WIDTH'(0): slave_readdata = {28'd0, err_r, busy_r, done_r, 1'b0};
        ADDRESS_WIDTH'(1): slave_readdata = src_r;
        ADDRESS_WIDTH'(2): slave_readdata = dst_r;
        ADDRESS_WIDTH'(3): slave_readdata = result_r;
        default:           slave_readdata = 32'd0;
      endcase
    end else begin
      slave_readdata = 32'hFFFF_FFFF;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_nxt_s  = state_r;
    idx_nxt_s    = idx_r;
    timer_nxt_s  = timer_r;
    data_nxt_s   = data_r;
    result_nxt_s = result_r;
    set_busy_s   = 1'b0;
    clr_busy_s   = 1'b0;
    set_done_s   = 1'b0;
    set_err_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_nxt_s = S_FETCH;
          idx_nxt_s   = 3'd0;
          set_busy_s  = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (!mem_waitrequest) begin
          data_nxt_s  = mem_readdata;
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_LOAD: begin
        if (!acc_waitrequest) begin
          if (idx_r == LAST_IDX) begin
            state_nxt_s = S_START;
          end else begin
            idx_nxt_s   = idx_r + 3'd1;
            state_nxt_s = S_FETCH;
          end
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_START: begin
        if (!acc_waitrequest) begin
          timer_nxt_s = {TW{1'b0}};
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_WAIT: begin
        if (acc_irq) begin
          state_nxt_s = S_COLLECT;
        end else if (timer_r == TIMEOUT_V) begin
          set_err_s   = 1'b1;
          state_nxt_s = S_CLEAR;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
      S_COLLECT: begin
        if (!acc_waitrequest) begin
          result_nxt_s = acc_readdata;
          state_nxt_s  = S_STORE;
        end else begin
          state_nxt_s = S_COLLECT;
        end
      end
      S_STORE: begin
        if (!mem_waitrequest) begin
          state_nxt_s = S_CLEAR;
        end else begin
          state_nxt_s = S_STORE;
        end
      end
      S_CLEAR: begin
        if (!acc_waitrequest) begin
          clr_busy_s  = 1'b1;
          set_done_s  = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_CLEAR;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they can be registered
  always_comb begin
    mem_read_nxt_s      = (state_nxt_s == S_FETCH);
    mem_write_nxt_s     = (state_nxt_s == S_STORE);
    acc_read_nxt_s      = (state_nxt_s == S_COLLECT);
    acc_write_nxt_s     = (state_nxt_s == S_LOAD) || (state_nxt_s == S_START) ||
                          (state_nxt_s == S_CLEAR);
    mem_address_nxt_s   = 32'd0;
    mem_writedata_nxt_s = 32'd0;
    acc_address_nxt_s   = 3'd0;
    acc_writedata_nxt_s = 32'd0;
    case (state_nxt_s)
      S_FETCH:   mem_address_nxt_s = src_r + {27'd0, idx_nxt_s, 2'b00};
      S_LOAD: begin
        acc_address_nxt_s   = 3'd2 + idx_nxt_s;
        acc_writedata_nxt_s = data_nxt_s;
      end
      S_START:   acc_writedata_nxt_s = 32'd1;
      S_COLLECT: acc_address_nxt_s   = 3'd1;
      S_STORE: begin
        mem_address_nxt_s   = dst_r;
        mem_writedata_nxt_s = result_nxt_s;
      end
      default: acc_writedata_nxt_s = 32'd0;
    endcase
  end

  // State, datapath, CSRs and registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= S_IDLE;
      idx_r         <= 3'd0;
      timer_r       <= {TW{1'b0}};
      data_r        <= 32'd0;
      result_r      <= 32'd0;
      src_r         <= 32'd0;
      dst_r         <= 32'd0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      err_r         <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      acc_read      <= 1'b0;
      acc_write     <= 1'b0;
      mem_address   <= 32'd0;
      mem_writedata <= 32'd0;
      acc_address   <= 3'd0;
      acc_writedata <= 32'd0;
    end else begin
      state_r  <= state_nxt_s;
      idx_r    <= idx_nxt_s;
      timer_r  <= timer_nxt_s;
      data_r   <= data_nxt_s;
      result_r <= result_nxt_s;
      if (slave_write && !busy_r && (slave_address == ADDRESS_WIDTH'(1))) src_r <= slave_writedata;
      if (slave_write && !busy_r && (slave_address == ADDRESS_WIDTH'(2))) dst_r <= slave_writedata;
      // Flag sets take priority over a software clear in the same cycle
      if (set_busy_s) busy_r <= 1'b1;
      else if (clr_busy_s) busy_r <= 1'b0;
      if (set_done_s) done_r <= 1'b1;
      else if (clr_flags_s) done_r <= 1'b0;
      if (set_err_s) err_r <= 1'b1;
      else if (clr_flags_s) err_r <= 1'b0;
      mem_read      <= mem_read_nxt_s;
      mem_write     <= mem_write_nxt_s;
      acc_read      <= acc_read_nxt_s;
      acc_write     <= acc_write_nxt_s;
      mem_address   <= mem_address_nxt_s;
      mem_writedata <= mem_writedata_nxt_s;
      acc_address   <= acc_address_nxt_s;
      acc_writedata <= acc_writedata_nxt_s;
    end
  end

endmodule

// File: doc/vector_op_loader.md
Name: vector_op_loader

Overview:
- Avalon-MM bridge that feeds the vector_op accelerator. The CPU programs a source and a destination address, then sets start.
- The block fetches OPERANDS words from system memory and writes them into the accelerator operand registers 2..OPERANDS+1. It then starts the accelerator, waits for its done interrupt, reads the result register, stores it to memory and returns the accelerator to IDLE.
- It sits between the CPU/system interconnect (CSR slave plus memory master) and the vector_op slave port (accelerator master).

Parameters:
- ADDRESS_WIDTH, 2, CSR slave word-address width.
- OPERANDS, 4, number of operand words transferred (1..6).
- TIMEOUT, 1023, maximum cycles spent in WAIT before abort.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- slave_address  in  ADDRESS_WIDTH  CSR word address
- slave_read  in  1  CSR read strobe
- slave_readdata  out  32  CSR read data, combinational; 32'hFFFFFFFF when not reading
- slave_write  in  1  CSR write strobe
- slave_writedata  in  32  CSR write data
- slave_waitrequest  out  1  tied 0
- mem_address  out  32  byte address to system memory
- mem_read, mem_write  out  1  memory strobes
- mem_writedata  out  32  data written to memory
- mem_readdata  in  32  memory read data, valid when mem_read && !mem_waitrequest
- mem_waitrequest  in  1  memory stall
- acc_address  out  3  accelerator word address
- acc_read, acc_write  out  1  accelerator strobes
- acc_writedata  out  32  accelerator write data
- acc_readdata  in  32  accelerator read data
- acc_waitrequest  in  1  accelerator stall
- acc_irq  in  1  accelerator done interrupt
- done_irq  out  1  equals CSR0 bit1

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- CSR map:
  - 0 CTRL/STATUS: bit0 start (write-1 pulse, reads 0), bit1 done, bit2 busy, bit3 timeout error.
  - 1 SRC: byte address.
  - 2 DST: byte address.
  - 3 RESULT: last result, read-only.
- Writing CTRL with bit1=1 clears done and error. Start is accepted only when not busy; otherwise it is ignored. SRC/DST writes while busy are ignored.
- Reset values: all CSRs 0, state IDLE, index 0, all strobes 0, addresses/writedata 0, done_irq 0.
- FSM states:
  - IDLE: on start, set busy, index i=0, go to FETCH.
  - FETCH: mem_read=1, mem_address=SRC+4*i. Hold until !mem_waitrequest, latch mem_readdata, go to LOAD.
  - LOAD: acc_write=1, acc_address=2+i, acc_writedata=latched word. Hold until !acc_waitrequest. If i==OPERANDS-1 go to START; else i++ and go to FETCH.
  - START: acc_write=1, acc_address=0, acc_writedata=1. On accept go to WAIT and clear the timeout counter.
  - WAIT: no strobes. If acc_irq go to COLLECT. Else if counter==TIMEOUT, set error and go to CLEAR. Else counter++.
  - COLLECT: acc_read=1, acc_address=1. On !acc_waitrequest latch acc_readdata into RESULT, go to STORE.
  - STORE: mem_write=1, mem_address=DST, mem_writedata=RESULT. On accept go to CLEAR.
  - CLEAR: acc_write=1, acc_address=0, acc_writedata=0. On accept clear busy, set done, go to IDLE.
- Strobes are registered outputs and stay asserted, with stable address and data, while the corresponding waitrequest is high. At most one master strobe is active per cycle.
- Address arithmetic is modulo 2^32 (SRC+4*i wraps silently).
- A CSR start write and a CLEAR completion in the same cycle: the start is ignored because busy is still set.
- A CSR done-clear write in the same cycle as the done-set: the set wins.
- Reset mid-operation: return to IDLE immediately and drop all strobes. The accelerator is not cleared; software must write acc CTRL via a fresh run.
- Latency with zero wait states: 2 cycles per operand + 1 START + wait + 1 COLLECT + 1 STORE + 1 CLEAR.

Test Plan:
- Memory words 1,2,3,4 at SRC=0x100, DST=0x200, start, accelerator model irq after 256 cycles with result 10 → acc writes to regs 2..5 = 1,2,3,4, then reg0=1, read reg1, mem write 0x200=10, reg0=0; done=1, done_irq=1, RESULT=10.
- Random mem_waitrequest/acc_waitrequest stalls on the same run → identical transaction sequence, strobe/address/data stable during stalls, same result 10.
- Start written while busy, and SRC rewritten to 0x300 mid-run → ignored; all fetches still use 0x100..0x10C.
- Accelerator never raises irq, TIMEOUT=1023 → error=1 at cycle 1024 of WAIT, no mem write, acc reg0 written 0, done=1.
- rst asserted during the WAIT state → all strobes 0, busy=0, CSRs 0 asynchronously. A subsequent start runs to completion.
- Write CTRL=0x2 after done → done=0, error=0, done_irq=0. Reads of CSR3 return the last result; reading with slave_read low → 0xFFFFFFFF.
